gmii_tx_ctrl: RTL and testbench

//  Transmit sequencer between the frame byte buffer and the GMII pins. Takes a

---
 rtl/gmii_tx_ctrl_if.sv | 12 +
 rtl/gmii_tx_ctrl.sv | 116 +++++++++++
 tb/tb_gmii_tx_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_tx_ctrl_if.sv
// gmii_tx_ctrl_if: frame buffer handshake between the byte buffer (master) and the TX sequencer (slave)
interface gmii_tx_ctrl_if #(parameter int LEN_W = 14);
    logic             frame_rdy;
    logic [LEN_W-1:0] frame_len;
    logic             frame_ack;
    logic             frame_drop;
    logic             rd_en;
    logic [7:0]       rd_data;
    logic             rd_empty;
    modport master (output frame_rdy, frame_len, rd_data, rd_empty, input frame_ack, frame_drop, rd_en);
    modport slave  (input frame_rdy, frame_len, rd_data, rd_empty, output frame_ack, frame_drop, rd_en);
endinterface

// File: rtl/gmii_tx_ctrl.sv
// gmii_tx_ctrl: sequences preamble, SFD, frame bytes, zero pad and IFG onto the GMII pins
module gmii_tx_ctrl #(
    parameter int PRE_LEN = 7,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int IFG_LEN = 12,
    parameter int LEN_W   = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_enable,
    gmii_tx_ctrl_if.slave        bif,
    output logic [7:0]           gmii_d,
    output logic                 gmii_tx_en,
    output logic                 gmii_tx_er,
    output logic                 underrun,
    output logic                 busy
);
    localparam int IFG_W = $clog2(IFG_LEN + 1);
    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, IFG} state_t;
    // state_q names what is currently on the wire; outputs are registered from state_d
    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d, len_q, len_d;
    logic [IFG_W-1:0]   ifg_q, ifg_d;
    logic               err_q, err_d;
    logic [7:0]         gmii_d_q, gmii_d_d;
    logic               tx_en_q, tx_en_d, tx_er_q, tx_er_d;
    logic               start, bad, need_pop;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            ifg_q    <= '0;
            err_q    <= 1'b0;
            gmii_d_q <= 8'h00;
            tx_en_q  <= 1'b0;
            tx_er_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            ifg_q    <= ifg_d;
            err_q    <= err_d;
            gmii_d_q <= gmii_d_d;
            tx_en_q  <= tx_en_d;
            tx_er_q  <= tx_er_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        ifg_d    = ifg_q;
        err_d    = 1'b0;
        need_pop = 1'b0;
        start    = (state_q == IDLE) && tx_enable && bif.frame_rdy;
        bad      = (bif.frame_len == '0) || (bif.frame_len > LEN_W'(MAX_LEN));
        case (state_q)
            IDLE: if (start) begin
                len_d = bif.frame_len;
                if (!bad) begin
                    state_d = PRE;
                    cnt_d   = LEN_W'(1);
                end
            end
            PRE: if (cnt_q == LEN_W'(PRE_LEN)) begin
                state_d = SFD;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            SFD: begin
                need_pop = 1'b1;
                err_d    = bif.rd_empty;
                state_d  = DATA;
                cnt_d    = LEN_W'(1);
            end
            // an underrun byte goes out first, then straight to IFG with no pad
            DATA: if (err_q) begin
                state_d = IFG;
                ifg_d   = IFG_W'(1);
            end else if (cnt_q < len_q) begin
                need_pop = 1'b1;
                err_d    = bif.rd_empty;
                cnt_d    = cnt_q + 1'b1;
            end else if (cnt_q < LEN_W'(MIN_LEN)) begin
                state_d = PAD;
                cnt_d   = cnt_q + 1'b1;
            end else begin
                state_d = IFG;
                ifg_d   = IFG_W'(1);
            end
            PAD: if (cnt_q < LEN_W'(MIN_LEN)) cnt_d = cnt_q + 1'b1;
            else begin
                state_d = IFG;
                ifg_d   = IFG_W'(1);
            end
            IFG: if (ifg_q == IFG_W'(IFG_LEN)) state_d = IDLE;
            else ifg_d = ifg_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        tx_en_d        = state_d inside {PRE, SFD, DATA, PAD};
        tx_er_d        = err_d;
        gmii_d_d       = state_d == PRE ? 8'h55 : state_d == SFD ? 8'hD5 :
                         (state_d == DATA && !err_d) ? bif.rd_data : 8'h00;
        bif.frame_ack  = !rst && start;
        bif.frame_drop = !rst && start && bad;
        bif.rd_en      = !rst && need_pop && !bif.rd_empty;
        underrun       = !rst && need_pop && bif.rd_empty;
        busy           = !rst && state_q != IDLE;
    end
    assign gmii_d     = gmii_d_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
endmodule

// File: tb/tb_gmii_tx_ctrl.sv
// tb_gmii_tx_ctrl: directed scenarios against hand-computed GMII byte streams and pop counts
module tb_gmii_tx_ctrl;
    localparam int LEN_W = 14;
    logic clk = 1'b0, rst = 1'b1, tx_enable = 1'b0;
    logic [7:0] gmii_d;
    logic gmii_tx_en, gmii_tx_er, underrun, busy;
    gmii_tx_ctrl_if #(.LEN_W(LEN_W)) bif();
    gmii_tx_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .tx_enable(tx_enable), .bif(bif),
        .gmii_d(gmii_d), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .underrun(underrun), .busy(busy)
    );
    always #5 clk = ~clk;
    logic [7:0] mem [0:4095];
    int rd_ptr = 0, avail = 4096;
    logic flush = 1'b0;
    initial for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    assign bif.rd_data  = mem[rd_ptr[11:0]];
    assign bif.rd_empty = rd_ptr >= avail;
    always @(posedge clk) rd_ptr <= flush ? 0 : rd_ptr + (bif.rd_en ? 1 : 0);
    int cyc = 0, rd_cnt = 0, tx_cnt = 0, un_cnt = 0, er_cnt = 0, ack_cnt = 0, drop_cnt = 0;
    int fall_cyc = 0, last_gap = 0;
    logic prev_en = 1'b0;
    logic [7:0] wq [$];
    logic eq [$];
    always @(negedge clk) begin
        cyc++;
        if (bif.rd_en) rd_cnt++;
        if (underrun) un_cnt++;
        if (gmii_tx_er) er_cnt++;
        if (bif.frame_ack) ack_cnt++;
        if (bif.frame_drop) drop_cnt++;
        if (gmii_tx_en) begin
            tx_cnt++;
            wq.push_back(gmii_d);
            eq.push_back(gmii_tx_er);
        end
        if (gmii_tx_en && !prev_en) last_gap = cyc - fall_cyc;
        if (!gmii_tx_en && prev_en) fall_cyc = cyc;
        prev_en = gmii_tx_en;
    end
    int tests = 0, fails = 0;
    task automatic start_frame(input int len);
        bit got = 0;
        @(posedge clk); #2;
        bif.frame_rdy = 1'b1;
        bif.frame_len = LEN_W'(len);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bif.frame_ack;
        end
        @(posedge clk); #2;
        bif.frame_rdy = 1'b0;
        tests++;
        if (!got) begin fails++; $display("FAIL start_frame len=%0d: frame_ack got 0 want 1", len); end
    endtask
    task automatic wait_idle();
        @(posedge clk);
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL wait_idle: busy got %b want 0", busy); end
    endtask
    task automatic do_flush();
        @(posedge clk); #2; flush = 1'b1;
        @(posedge clk); #2; flush = 1'b0;
    endtask
    task automatic test_reset();
        bif.frame_rdy = 1'b0; bif.frame_len = '0; flush = 1'b1; rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({gmii_tx_en, gmii_tx_er, gmii_d, busy, underrun, bif.rd_en, bif.frame_ack} !== 14'h0) begin
            fails++; $display("FAIL reset_outputs: got en=%b er=%b d=%h busy=%b want all 0", gmii_tx_en, gmii_tx_er, gmii_d, busy);
        end
        #1 rst = 1'b0; flush = 1'b0; tx_enable = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || gmii_tx_en !== 1'b0) begin fails++; $display("FAIL reset_release: busy=%b en=%b want 0 0", busy, gmii_tx_en); end
    endtask
    task automatic test_long();
        int p = rd_ptr, w = wq.size(), r0 = rd_cnt, t0 = tx_cnt, e0 = er_cnt, bad = 0;
        logic [7:0] exp_b;
        start_frame(100);
        wait_idle();
        tests++;
        if (tx_cnt - t0 !== 108) begin fails++; $display("FAIL long_tx_en: got %0d cycles want 108", tx_cnt - t0); end
        tests++;
        if (rd_cnt - r0 !== 100) begin fails++; $display("FAIL long_rd_en: got %0d pops want 100", rd_cnt - r0); end
        for (int k = 0; k < 108 && w + k < wq.size(); k++) begin
            exp_b = k < 7 ? 8'h55 : k == 7 ? 8'hD5 : mem[p + k - 8];
            if (wq[w + k] !== exp_b) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL long_bytes: got %0d wrong bytes want 0", bad); end
        tests++;
        if (er_cnt - e0 !== 0) begin fails++; $display("FAIL long_tx_er: got %0d want 0", er_cnt - e0); end
    endtask
    task automatic test_pad();
        int p = rd_ptr, w = wq.size(), r0 = rd_cnt, t0 = tx_cnt, bad = 0;
        logic [7:0] exp_b;
        start_frame(20);
        wait_idle();
        tests++;
        if (tx_cnt - t0 !== 68) begin fails++; $display("FAIL pad_tx_en: got %0d cycles want 68", tx_cnt - t0); end
        tests++;
        if (rd_cnt - r0 !== 20) begin fails++; $display("FAIL pad_rd_en: got %0d pops want 20", rd_cnt - r0); end
        for (int k = 0; k < 68 && w + k < wq.size(); k++) begin
            exp_b = k < 7 ? 8'h55 : k == 7 ? 8'hD5 : k < 28 ? mem[p + k - 8] : 8'h00;
            if (wq[w + k] !== exp_b) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL pad_bytes: got %0d wrong bytes want 0", bad); end
    endtask
    task automatic test_drop();
        int lens [2] = '{0, 1515};
        foreach (lens[j]) begin
            int r0 = rd_cnt, t0 = tx_cnt, a0 = ack_cnt;
            bit got = 0, drp = 0;
            @(posedge clk); #2;
            bif.frame_rdy = 1'b1;
            bif.frame_len = LEN_W'(lens[j]);
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = bif.frame_ack;
                drp = bif.frame_drop;
            end
            @(posedge clk); #2;
            bif.frame_rdy = 1'b0;
            repeat (5) @(negedge clk);
            tests++;
            if (!(got && drp)) begin fails++; $display("FAIL drop_pulse len=%0d: ack=%b drop=%b want 1 1", lens[j], got, drp); end
            tests++;
            if (ack_cnt - a0 !== 1) begin fails++; $display("FAIL drop_ack_count len=%0d: got %0d want 1", lens[j], ack_cnt - a0); end
            tests++;
            if (rd_cnt - r0 !== 0 || tx_cnt - t0 !== 0 || busy !== 1'b0) begin
                fails++; $display("FAIL drop_quiet len=%0d: pops=%0d tx_en=%0d busy=%b want 0 0 0", lens[j], rd_cnt - r0, tx_cnt - t0, busy);
            end
        end
    endtask
    task automatic test_underrun();
        int w, r0, t0, u0, e0, bad = 0;
        do_flush();
        avail = 50;
        w = wq.size(); r0 = rd_cnt; t0 = tx_cnt; u0 = un_cnt; e0 = er_cnt;
        start_frame(100);
        wait_idle();
        tests++;
        if (un_cnt - u0 !== 1) begin fails++; $display("FAIL underrun_pulse: got %0d want 1", un_cnt - u0); end
        tests++;
        if (rd_cnt - r0 !== 50) begin fails++; $display("FAIL underrun_rd_en: got %0d pops want 50", rd_cnt - r0); end
        tests++;
        if (tx_cnt - t0 !== 59) begin fails++; $display("FAIL underrun_tx_en: got %0d cycles want 59", tx_cnt - t0); end
        for (int k = 8; k < 58 && w + k < wq.size(); k++) if (wq[w + k] !== mem[k - 8] || eq[w + k] !== 1'b0) bad++;
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL underrun_good_bytes: got %0d wrong want 0", bad); end
        tests++;
        if (er_cnt - e0 !== 1 || wq.size() < w + 59 || eq[w + 58] !== 1'b1 || wq[w + 58] !== 8'h00) begin
            fails++; $display("FAIL underrun_err_byte: er_cycles=%0d want 1 with d=00 on last byte", er_cnt - e0);
        end
        avail = 4096;
        do_flush();
    endtask
    task automatic test_back_to_back();
        int p = rd_ptr, w = wq.size(), r0 = rd_cnt, t0 = tx_cnt, n = 0, bad = 0;
        logic [7:0] exp_b;
        @(posedge clk); #2;
        bif.frame_rdy = 1'b1;
        bif.frame_len = LEN_W'(64);
        for (int i = 0; i < 1000 && n < 2; i++) begin
            @(negedge clk);
            if (bif.frame_ack) n++;
        end
        @(posedge clk); #2;
        bif.frame_rdy = 1'b0;
        wait_idle();
        tests++;
        if (n !== 2) begin fails++; $display("FAIL b2b_acks: got %0d want 2", n); end
        tests++;
        if (last_gap < 13) begin fails++; $display("FAIL b2b_gap: got %0d idle cycles want >=13", last_gap); end
        tests++;
        if (tx_cnt - t0 !== 144 || rd_cnt - r0 !== 128) begin
            fails++; $display("FAIL b2b_counts: tx_en=%0d pops=%0d want 144 128", tx_cnt - t0, rd_cnt - r0);
        end
        for (int k = 0; k < 144 && w + k < wq.size(); k++) begin
            int m = k % 72;
            exp_b = m < 7 ? 8'h55 : m == 7 ? 8'hD5 : mem[p + (k / 72) * 64 + m - 8];
            if (wq[w + k] !== exp_b) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL b2b_bytes: got %0d wrong want 0", bad); end
    endtask
    task automatic test_reset_abort();
        int r0, t0, a0;
        do_flush();
        start_frame(100);
        for (int i = 0; i < 300 && rd_ptr < 30; i++) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (gmii_tx_en !== 1'b0 || gmii_d !== 8'h00 || busy !== 1'b0 || bif.rd_en !== 1'b0) begin
            fails++; $display("FAIL abort_in_reset: en=%b d=%h busy=%b rd_en=%b want 0", gmii_tx_en, gmii_d, busy, bif.rd_en);
        end
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (gmii_tx_en !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL abort_after_reset: en=%b busy=%b want 0 0", gmii_tx_en, busy); end
        do_flush();
        r0 = rd_cnt; t0 = tx_cnt;
        start_frame(60);
        tx_enable = 1'b0;
        wait_idle();
        tests++;
        if (tx_cnt - t0 !== 68 || rd_cnt - r0 !== 60) begin
            fails++; $display("FAIL txen_low_completes: tx_en=%0d pops=%0d want 68 60", tx_cnt - t0, rd_cnt - r0);
        end
        a0 = ack_cnt;
        @(posedge clk); #2 bif.frame_rdy = 1'b1;
        repeat (20) @(negedge clk);
        tests++;
        if (ack_cnt - a0 !== 0 || busy !== 1'b0) begin fails++; $display("FAIL txen_low_gate: acks=%0d busy=%b want 0 0", ack_cnt - a0, busy); end
        @(posedge clk); #2 bif.frame_rdy = 1'b0; tx_enable = 1'b1;
    endtask
    initial begin
        test_reset();
        test_long();
        test_pad();
        test_drop();
        test_underrun();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
